// File: rtl/ecc_pkg.sv
// Shared ECC definitions: default operand width and the arbiter FSM state encoding.
package ecc_pkg;

  localparam int LEN_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mod_sub.sv
// Combinational modular subtract c = (a - b) mod p, wrapping by adding p on borrow.
// Zero latency, no flow control; out-of-range operands follow the same formula truncated to LEN bits.
module mod_sub #(
  parameter int LEN = 256
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  output logic [LEN-1:0] c
);

  logic [LEN:0]   diff;
  logic [LEN-1:0] wrap;

  // diff[LEN] is the borrow, i.e. a < b; adding p modulo 2^LEN fixes it up
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    wrap = diff[LEN-1:0] + p;
    c    = diff[LEN] ? wrap : diff[LEN-1:0];
  end

endmodule

// File: rtl/mod_sub_arbiter.sv
// Round-robin share of one mod_sub among NREQ requesters, one op in flight: resp_valid 2 cycles after accept, issue every 3.
// req_ready is only offered in IDLE; the response holds stable while resp_ready is low.
module mod_sub_arbiter
  import ecc_pkg::*;
#(
  parameter int LEN  = LEN_DEFAULT,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*LEN-1:0]      req_a,
  input  logic [NREQ*LEN-1:0]      req_b,
  input  logic [NREQ*LEN-1:0]      req_p,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LEN-1:0]           resp_data,
  output logic [$clog2(NREQ)-1:0]  resp_id
);

  localparam int ID_W = $clog2(NREQ);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            accept;

  logic [LEN-1:0]  sel_a;
  logic [LEN-1:0]  sel_b;
  logic [LEN-1:0]  sel_p;
  logic [LEN-1:0]  a_q;
  logic [LEN-1:0]  b_q;
  logic [LEN-1:0]  p_q;
  logic [ID_W-1:0] id_q;
  logic [LEN-1:0]  calc;

  // First valid requester at or above the pointer, wrapping past NREQ-1
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_w = idx[ID_W-1:0];
      if (!found && req_valid[idx_w]) begin
        found = 1'b1;
        grant = idx_w;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_p = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a[i*LEN +: LEN];
        sel_b = req_b[i*LEN +: LEN];
        sel_p = req_p[i*LEN +: LEN];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          req_ready[grant] = 1'b1;
          state_nxt        = CALC;
        end
      end
      CALC:    state_nxt = RESP;
      RESP: begin
        if (resp_valid && resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |(req_valid & req_ready);

  mod_sub #(
    .LEN (LEN)
  ) u_mod_sub (
    .a (a_q),
    .b (b_q),
    .p (p_q),
    .c (calc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        p_q  <= sel_p;
        id_q <= grant;
        ptr  <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
      end
      if (state == CALC) begin
        resp_data  <= calc;
        resp_id    <= id_q;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mod_sub_arbiter.md
MOD_SUB_ARBITER -- requirements
Module: mod_sub_arbiter

Interface
REQ-001 Parameter: LEN, default 256, operand and modulus width in bits.
REQ-002 Parameter: NREQ, default 4, number of requesters; legal range 2..8.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: req_valid  input  NREQ  per-requester operation request.
REQ-006 Port: req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port: req_a  input  NREQ*LEN  minuend per requester; slot i at bits [i*LEN +: LEN].
REQ-008 Port: req_b  input  NREQ*LEN  subtrahend per requester, same packing.
REQ-009 Port: req_p  input  NREQ*LEN  modulus per requester, same packing.
REQ-010 Port: resp_valid  output  1  result available on the shared response bus.
REQ-011 Port: resp_ready  input  1  consumer accepts the result.
REQ-012 Port: resp_data  output  LEN  result (a - b) mod p.
REQ-013 Port: resp_id  output  $clog2(NREQ)  index of the requester that owns resp_data.

Function
REQ-014 The block shall time-share one combinational mod_sub datapath among NREQ requesters, with one operation in flight at a time.
REQ-015 FSM states shall be IDLE, CALC and RESP.
- IDLE -> CALC on accept.
- CALC -> RESP unconditionally after one cycle.
- RESP -> IDLE on resp_valid & resp_ready.
REQ-016 In IDLE, the grant shall be the first index with req_valid high, searching round-robin from the priority pointer upward with wrap from NREQ-1 to 0; req_ready[grant] shall be high combinationally.
REQ-017 req_ready shall be all-zero in CALC and RESP, and in IDLE when no req_valid bit is set.
REQ-018 An accept is req_valid[i] & req_ready[i]; on an accept the block shall latch a, b, p and id for index i.
REQ-019 On an accept, the priority pointer shall become (i+1) mod NREQ; otherwise it shall hold.
REQ-020 In CALC, the mod_sub output shall be registered into resp_data, and resp_valid shall rise on the next edge.
- Latency from the accept edge to resp_valid high is 2 cycles.
- Minimum issue interval is 3 cycles.
REQ-021 Arithmetic: a - b shall be computed in LEN+1 bits; result = a-b if a>=b, else a-b+p, truncated to LEN bits.
REQ-022 The requester contract is a<p and b<p; with out-of-range operands the REQ-021 formula still applies bit-exactly, and no error shall be flagged.
REQ-023 resp_data, resp_id and resp_valid shall hold stable while resp_valid & !resp_ready (backpressure of any length).
REQ-024 No new accept shall occur in the same cycle as the response handshake; the next accept is possible the cycle after the block returns to IDLE.
REQ-025 A requester that drops req_valid while not granted shall not be served; operands shall be sampled only at accept.
REQ-026 The block shall not depend on p=0; that case shall yield a-b truncated, with no hang.

Reset
REQ-027 When rst_n=0 at a clock edge, the block shall set the following, regardless of current state:
- state=IDLE, pointer=0, resp_valid=0;
- resp_data=0, resp_id=0;
- latched operands=0.
REQ-028 Reset in CALC or RESP shall discard the in-flight operation; no response shall be produced for it.
REQ-029 req_ready shall be all-zero while rst_n=0.

Structure
REQ-030 The FSM state enum (IDLE/CALC/RESP) shall live in the shared ECC package ecc_pkg, alongside the default LEN constant.
REQ-031 The existing mod_sub module (parameter LEN; ports a, b, p, c) shall be instantiated exactly once as the only sub-module; the arbiter shall contain the round-robin logic inline.

Verification
REQ-032 The bench shall cover these directed scenarios (LEN=8, NREQ=4 unless stated):
- Single requester 0: a=78, b=31, p=113 -> resp_data=47, resp_id=0, resp_valid high 2 cycles after accept.
- Requester 2: a=28, b=37, p=47 (wrap case) -> resp_data=38, resp_id=2.
- All four req_valid held high, resp_ready=1 -> grants 0,1,2,3,0 in order; one grant every 3 cycles.
- Pointer at 3, only requesters 1 and 3 valid -> 3 is served first, then 1.
- resp_ready=0 for 5 cycles after resp_valid -> resp_data/resp_id stable, req_ready all-zero, completes on resp_ready=1.
- rst_n=0 during CALC -> no resp_valid; pointer=0; next request from requester 1 (a=5, b=9, p=11) -> resp_data=7.
